// File: rtl/if_id_queue_if.sv
// Fetch-to-decode handshake bundle: IF push side, ID pop side, flush and occupancy.
// The slave modport is the queue; the master modport is the surrounding pipeline.
interface if_id_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int CNT_WIDTH  = 3
);
    logic                  flush;
    logic                  ifValid;
    logic [ADDR_WIDTH-1:0] ifPC;
    logic [INST_WIDTH-1:0] ifInst;
    logic                  ifReady;
    logic                  idValid;
    logic [ADDR_WIDTH-1:0] idPC;
    logic [INST_WIDTH-1:0] idInst;
    logic                  idReady;
    logic [CNT_WIDTH-1:0]  count;

    modport slave (
        input  flush, ifValid, ifPC, ifInst, idReady,
        output ifReady, idValid, idPC, idInst, count
    );

    modport master (
        output flush, ifValid, ifPC, ifInst, idReady,
        input  ifReady, idValid, idPC, idInst, count
    );
endinterface

// File: rtl/if_id_queue.sv
// Circular-buffer IF/ID queue: DEPTH (PC, instruction) pairs in FIFO order,
// valid/ready on both sides, synchronous flush, NOP presented to ID when empty.
module if_id_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave q
);
    localparam int                   PTR_W = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL  = CNT_WIDTH'(DEPTH);

    logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]      head, tail;
    logic [CNT_WIDTH-1:0]  cnt;
    logic                  push, pop;

    // Ready comes from registered occupancy only, so ID stalls never ripple into IF.
    assign q.ifReady = (cnt != FULL);
    assign q.idValid = (cnt != '0);
    assign push      = q.ifValid & q.ifReady & ~q.flush;
    assign pop       = q.idValid & q.idReady & ~q.flush;

    assign q.idPC   = q.idValid ? pc_mem[head]   : '0;
    assign q.idInst = q.idValid ? inst_mem[head] : '0;
    assign q.count  = cnt;

    // Storage is not reset; head/count gate what ID can see.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]   <= q.ifPC;
            inst_mem[tail] <= q.ifInst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else if (q.flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CNT_WIDTH'(1);
                2'b01:   cnt <= cnt - CNT_WIDTH'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: expected entries queued on push, compared
// against the ID side on each pop, plus per-scenario occupancy/handshake checks.
module tb_if_id_queue;
    localparam int AW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;
    ent_t sb[$];

    if_id_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    if_id_queue #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            assert (int'(bus.count) <= DEPTH) else $error("occupancy overflow %0d", bus.count);
            assert (bus.idValid == (bus.count != '0)) else $error("idValid/count disagree");
        end
    end

    // One clock of stimulus; the scoreboard checks the head on every modelled pop.
    task automatic step(input logic v, input logic [AW-1:0] pc, input logic [IW-1:0] inst,
                        input logic rdy, input logic fl);
        logic push, pop;
        ent_t exp;
        bus.ifValid = v;
        bus.ifPC    = pc;
        bus.ifInst  = inst;
        bus.idReady = rdy;
        bus.flush   = fl;
        #1;
        push = v && (sb.size() != DEPTH) && !fl;
        pop  = (sb.size() != 0) && rdy && !fl;
        if (pop) begin
            exp = sb[0];
            vectors++;
            if (bus.idPC !== exp.pc || bus.idInst !== exp.inst) begin
                errors++;
                $display("FAIL pop_head: got pc=%h inst=%h, want pc=%h inst=%h",
                         bus.idPC, bus.idInst, exp.pc, exp.inst);
            end
        end
        @(posedge clk);
        if (fl) sb.delete();
        else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back('{pc: pc, inst: inst});
        end
        #1;
        bus.ifValid = 1'b0;
        bus.idReady = 1'b0;
        bus.flush   = 1'b0;
    endtask

    task automatic test_reset;
        vectors++; if (bus.ifReady !== 1'b1) begin errors++; $display("FAIL rst_ifReady: got %b want 1", bus.ifReady); end
        vectors++; if (bus.idValid !== 1'b0) begin errors++; $display("FAIL rst_idValid: got %b want 0", bus.idValid); end
        vectors++; if (bus.idPC !== '0) begin errors++; $display("FAIL rst_idPC: got %h want 0", bus.idPC); end
        vectors++; if (bus.idInst !== '0) begin errors++; $display("FAIL rst_idInst: got %h want 0", bus.idInst); end
        vectors++; if (bus.count !== '0) begin errors++; $display("FAIL rst_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_single;
        bus.ifValid = 1'b1; bus.ifPC = 32'd15; bus.ifInst = 32'hAAAAAAAA;
        #1;
        vectors++; if (bus.idValid !== 1'b0) begin errors++; $display("FAIL single_pre_valid: got %b want 0", bus.idValid); end
        vectors++; if (bus.idInst !== '0) begin errors++; $display("FAIL single_pre_inst: got %h want 0", bus.idInst); end
        step(1'b1, 32'd15, 32'hAAAAAAAA, 1'b0, 1'b0);
        vectors++; if (bus.idValid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.idValid); end
        vectors++; if (bus.idPC !== 32'd15) begin errors++; $display("FAIL single_pc: got %0d want 15", bus.idPC); end
        vectors++; if (bus.idInst !== 32'hAAAAAAAA) begin errors++; $display("FAIL single_inst: got %h want aaaaaaaa", bus.idInst); end
        vectors++; if (bus.count !== CW'(1)) begin errors++; $display("FAIL single_count: got %0d want 1", bus.count); end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (bus.count !== '0) begin errors++; $display("FAIL single_drain: got %0d want 0", bus.count); end
    endtask

    task automatic test_fill;
        for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i * 4), IW'(32'h1000 + i), 1'b0, 1'b0);
        vectors++; if (bus.count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_count: got %0d want %0d", bus.count, DEPTH); end
        vectors++; if (bus.ifReady !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b want 0", bus.ifReady); end
        step(1'b1, 32'd16, 32'h2000, 1'b0, 1'b0);
        vectors++; if (bus.count !== CW'(DEPTH)) begin errors++; $display("FAIL fill_extra_count: got %0d want %0d", bus.count, DEPTH); end
        vectors++; if (bus.idPC !== 32'd0) begin errors++; $display("FAIL fill_head: got %0d want 0", bus.idPC); end
    endtask

    task automatic test_drain;
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (bus.idPC !== AW'(i * 4)) begin errors++; $display("FAIL drain_order: got %0d want %0d", bus.idPC, i * 4); end
            step(1'b0, '0, '0, 1'b1, 1'b0);
        end
        vectors++; if (bus.idValid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", bus.idValid); end
        vectors++; if (bus.idPC !== '0) begin errors++; $display("FAIL drain_pc: got %h want 0", bus.idPC); end
        vectors++; if (bus.count !== '0) begin errors++; $display("FAIL drain_count: got %0d want 0", bus.count); end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 32'd200, 32'h3000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, AW'(i * 4), IW'($urandom), 1'b1, 1'b0);
            vectors++;
            if (bus.count !== CW'(1)) begin errors++; $display("FAIL stream_count[%0d]: got %0d want 1", i, bus.count); end
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        vectors++; if (bus.count !== '0 || sb.size() != 0) begin errors++; $display("FAIL stream_end: got count %0d want 0", bus.count); end
    endtask

    task automatic test_flush;
        for (int i = 0; i < 3; i++) step(1'b1, AW'(40 + i * 4), IW'(32'h4000 + i), 1'b0, 1'b0);
        vectors++; if (bus.count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", bus.count); end
        step(1'b1, 32'd77, 32'h5000, 1'b1, 1'b1);
        vectors++; if (bus.count !== '0) begin errors++; $display("FAIL flush_count: got %0d want 0", bus.count); end
        vectors++; if (bus.idValid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.idValid); end
        vectors++; if (bus.ifReady !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", bus.ifReady); end
        step(1'b1, 32'd100, 32'h6000, 1'b0, 1'b0);
        vectors++; if (bus.count !== CW'(1)) begin errors++; $display("FAIL flush_next_count: got %0d want 1", bus.count); end
        vectors++; if (bus.idPC !== 32'd100) begin errors++; $display("FAIL flush_next_head: got %0d want 100", bus.idPC); end
        step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset;
        step(1'b1, 32'd300, 32'h7000, 1'b0, 1'b0);
        step(1'b1, 32'd304, 32'h7001, 1'b0, 1'b0);
        vectors++; if (bus.count !== CW'(2)) begin errors++; $display("FAIL arst_pre_count: got %0d want 2", bus.count); end
        #2 rst = 1'b1;
        #1;
        vectors++; if (bus.idValid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.idValid); end
        vectors++; if (bus.count !== '0) begin errors++; $display("FAIL arst_count: got %0d want 0", bus.count); end
        vectors++; if (bus.ifReady !== 1'b1) begin errors++; $display("FAIL arst_ready: got %b want 1", bus.ifReady); end
        vectors++; if (bus.idPC !== '0) begin errors++; $display("FAIL arst_pc: got %h want 0", bus.idPC); end
        sb.delete();
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0; bus.ifValid = 1'b0; bus.ifPC = '0; bus.ifInst = '0; bus.idReady = 1'b0;
        #1;
        test_reset;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        test_single;
        test_fill;
        test_drain;
        test_back_to_back;
        test_flush;
        test_async_reset;
        @(posedge clk); #1;
        test_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
